// File: rtl/seg_mux_driver.sv
// rtl/seg_mux_driver.sv - time-multiplexed seven-segment driver with dead-time guard
// Outputs are registered from the current state, so the display lags the sequencer by one cycle.
module seg_mux_driver #(
  parameter int NUM_DIGITS     = 2,
  parameter int REFRESH_DIV    = 24000,
  parameter int BLANK_CYCLES   = 16,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                      clk_i,
  input  logic                      reset_ni,
  input  logic [4*NUM_DIGITS-1:0]   digits_i,
  input  logic [NUM_DIGITS-1:0]     blank_mask_i,
  output logic [6:0]                seg_o,
  output logic [NUM_DIGITS-1:0]     an_o,
  output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] cur_digit_o,
  output logic                      frame_start_o
);

  localparam int IW        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW        = $clog2(REFRESH_DIV);
  localparam int ON_CYCLES = REFRESH_DIV - BLANK_CYCLES;

  localparam logic [CW-1:0]         GUARD_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0]         ON_LAST    = CW'(ON_CYCLES - 1);
  localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [6:0]            SEG_OFF    = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF     = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;

  typedef enum logic {S_GUARD, S_ON} state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] digit_snap_q;
  logic [NUM_DIGITS-1:0]   blank_snap_q;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [IW-1:0]           cur_q, cur_d;
  logic                    fs_q, fs_d;
  logic                    snap_en;
  logic [3:0]              nibble;
  logic                    lit;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'h0: decode = 7'b0111111;
      4'h1: decode = 7'b0000110;
      4'h2: decode = 7'b1011011;
      4'h3: decode = 7'b1001111;
      4'h4: decode = 7'b1100110;
      4'h5: decode = 7'b1101101;
      4'h6: decode = 7'b1111101;
      4'h7: decode = 7'b0000111;
      4'h8: decode = 7'b1111111;
      4'h9: decode = 7'b1101111;
      4'hA: decode = 7'b1110111;
      4'hB: decode = 7'b1111100;
      4'hC: decode = 7'b0111001;
      4'hD: decode = 7'b1011110;
      4'hE: decode = 7'b1111001;
      default: decode = 7'b1110001;
    endcase
  endfunction

  // The frame snapshot is taken on the very first cycle of digit 0's guard.
  assign snap_en = (state_q == S_GUARD) && (idx_q == '0) && (cnt_q == '0);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= S_GUARD;
      cnt_q        <= '0;
      idx_q        <= '0;
      digit_snap_q <= '0;
      blank_snap_q <= '0;
      seg_q        <= SEG_OFF;
      an_q         <= AN_OFF;
      cur_q        <= '0;
      fs_q         <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      if (snap_en) begin
        digit_snap_q <= digits_i;
        blank_snap_q <= blank_mask_i;
      end
      seg_q <= seg_d;
      an_q  <= an_d;
      cur_q <= cur_d;
      fs_q  <= fs_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    case (state_q)
      S_GUARD: begin
        if (cnt_q == GUARD_LAST) begin
          state_d = S_ON;
          cnt_d   = '0;
        end
      end
      default: begin
        if (cnt_q == ON_LAST) begin
          state_d = S_GUARD;
          cnt_d   = '0;
          idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end
      end
    endcase
  end

  always_comb begin
    nibble = digit_snap_q[{idx_q, 2'b00} +: 4];
    lit    = (state_q == S_ON) && !blank_snap_q[idx_q];
    seg_d  = SEG_OFF;
    an_d   = AN_OFF;
    cur_d  = idx_q;
    fs_d   = snap_en;
    if (lit) begin
      seg_d = decode(nibble) ^ SEG_OFF;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (idx_q == IW'(i)) an_d[i] = ~AN_OFF[i];
      end
    end
  end

  assign seg_o         = seg_q;
  assign an_o          = an_q;
  assign cur_digit_o   = cur_q;
  assign frame_start_o = fs_q;

endmodule

// File: tb/tb_seg_mux_driver.sv
// tb/tb_seg_mux_driver.sv - scoreboard bench for seg_mux_driver (2 digits, 8-cycle slots, 2 guard)
module tb_seg_mux_driver;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] digits, digits_hi;
  logic [1:0] bmask, bmask_hi;
  logic [6:0] seg, seg_hi;
  logic [1:0] an, an_hi;
  logic       cur, cur_hi;
  logic       fs, fs_hi;

  int total = 0;
  int bad   = 0;
  logic [10:0] exp_q[$];
  logic [8:0]  sweep_q[$];

  always #5 clk = ~clk;

  seg_mux_driver #(
    .NUM_DIGITS(2), .REFRESH_DIV(8), .BLANK_CYCLES(2),
    .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
  ) dut (
    .clk_i(clk), .reset_ni(reset_n), .digits_i(digits), .blank_mask_i(bmask),
    .seg_o(seg), .an_o(an), .cur_digit_o(cur), .frame_start_o(fs)
  );

  seg_mux_driver #(
    .NUM_DIGITS(2), .REFRESH_DIV(8), .BLANK_CYCLES(2),
    .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)
  ) dut_hi (
    .clk_i(clk), .reset_ni(reset_n), .digits_i(digits_hi), .blank_mask_i(bmask_hi),
    .seg_o(seg_hi), .an_o(an_hi), .cur_digit_o(cur_hi), .frame_start_o(fs_hi)
  );

  function automatic logic [6:0] dec(input logic [3:0] v);
    case (v)
      4'h0: dec = 7'b0111111;
      4'h1: dec = 7'b0000110;
      4'h2: dec = 7'b1011011;
      4'h3: dec = 7'b1001111;
      4'h4: dec = 7'b1100110;
      4'h5: dec = 7'b1101101;
      4'h6: dec = 7'b1111101;
      4'h7: dec = 7'b0000111;
      4'h8: dec = 7'b1111111;
      4'h9: dec = 7'b1101111;
      4'hA: dec = 7'b1110111;
      4'hB: dec = 7'b1111100;
      4'hC: dec = 7'b0111001;
      4'hD: dec = 7'b1011110;
      4'hE: dec = 7'b1111001;
      default: dec = 7'b1110001;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One frame as seen on the pins: {frame_start, cur_digit, an, seg} per cycle after the snapshot edge.
  task automatic push_frame(input logic [7:0] d, input logic [1:0] bm);
    logic       f, c;
    logic [1:0] a;
    logic [6:0] s;
    for (int k = 0; k < 16; k++) begin
      f = (k == 0);
      c = (k >= 8);
      a = 2'b11;
      s = 7'h7F;
      if (k >= 2 && k < 8 && !bm[0]) begin
        a = 2'b10;
        s = ~dec(d[3:0]);
      end
      if (k >= 10 && !bm[1]) begin
        a = 2'b01;
        s = ~dec(d[7:4]);
      end
      exp_q.push_back({f, c, a, s});
    end
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_empty observed=no_entry expected=entry");
      end else begin
        chk($sformatf("cycle%0d", i), {fs, cur, an, seg}, exp_q.pop_front());
      end
      chk("an_exclusive", {10'b0, an == 2'b00}, 11'h0);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    digits    = 8'h3A;
    bmask     = 2'b00;
    digits_hi = 8'h00;
    bmask_hi  = 2'b00;
    repeat (3) @(negedge clk);
    chk("reset_low", {fs, cur, an, seg}, {1'b0, 1'b0, 2'b11, 7'h7F});
    chk("reset_high_pol", {fs_hi, cur_hi, an_hi, seg_hi}, 11'h000);

    // first frame after release, then four more to cover wrap and period
    reset_n = 1'b1;
    push_frame(8'h3A, 2'b00);
    run_cycles(16);
    for (int f = 0; f < 4; f++) begin
      push_frame(8'h3A, 2'b00);
      run_cycles(16);
    end

    // inputs change during digit 1's on time; display keeps the old snapshot
    push_frame(8'h3A, 2'b00);
    run_cycles(12);
    digits = 8'h5F;
    run_cycles(4);
    push_frame(8'h5F, 2'b00);
    run_cycles(16);

    digits = 8'h00;
    bmask  = 2'b10;
    push_frame(8'h00, 2'b10);
    run_cycles(16);

    // reset during the third on cycle of digit 1
    digits = 8'h3A;
    bmask  = 2'b00;
    push_frame(8'h3A, 2'b00);
    run_cycles(12);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 chk("midslot_reset", {fs, cur, an, seg}, {1'b0, 1'b0, 2'b11, 7'h7F});
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    push_frame(8'h3A, 2'b00);
    run_cycles(16);

    // active-high instance: one frame per hex value on digit 0
    for (int v = 0; v < 16; v++) begin
      digits_hi = {4'h0, 4'(v)};
      sweep_q.push_back({2'b01, dec(4'(v))});
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk($sformatf("sweep_%0d", v), {2'b00, an_hi, seg_hi}, {2'b00, sweep_q.pop_front()});
      repeat (13) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
